// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifq_pkg
// Purpose  : Shared types and default geometry for the instruction fetch
//            queue (IFQ) fetch sequencer.
//            - fetch_state_t : fetch FSM encoding (S_REQ, S_WAIT)
//            - LINE_BYTES, INST_BYTES, WPL, WIDX_W : default line geometry
//            The IFQ_* localparams supply default values for module parameters.
// Revision : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    localparam int IFQ_LINE_W = 128;
    localparam int IFQ_INST_W = 32;
    localparam int IFQ_PC_W   = 32;

    localparam int LINE_BYTES = IFQ_LINE_W / 8;
    localparam int INST_BYTES = IFQ_INST_W / 8;
    localparam int WPL        = IFQ_LINE_W / IFQ_INST_W;
    localparam int WIDX_W     = $clog2(WPL);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifq_dispatch_sel.sv
`default_nettype none
// ============================================================================
// Module   : ifq_dispatch_sel
// Purpose  : Slices the IFQ head line into single instructions for decode.
//            Tracks the word index within the head line and the dispatch PC,
//            and pulls the head line once its last word has been accepted.
// Ports    : clk, rst                      - clock, sync active-high reset
//            redirect_valid, redirect_pc   - branch re-steer
//            buf_empty, buf_data_read      - buffer status / head line
//            dec_ready                     - decode accepts
//            inst_valid, inst, inst_pc     - instruction offered to decode
//            buf_pull                      - head line fully consumed
// Revision : 1.0 - initial release
// ============================================================================
module ifq_dispatch_sel
    import ifq_pkg::*;
#(
    parameter int              LINE_W   = IFQ_LINE_W,
    parameter int              INST_W   = IFQ_INST_W,
    parameter int              PC_W     = IFQ_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              buf_empty,
    input  logic [LINE_W-1:0] buf_data_read,
    input  logic              dec_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              buf_pull
);

    // Words per line must be a power of two and at least 2.
    localparam int c_wpl        = LINE_W / INST_W;
    localparam int c_widx_w     = $clog2(c_wpl);
    localparam int c_inst_bytes = INST_W / 8;
    localparam int c_ioff_w     = $clog2(c_inst_bytes);
    localparam logic [c_widx_w-1:0] c_last_word = c_widx_w'(c_wpl - 1);

    logic [c_widx_w-1:0] r_rd_word;
    logic [PC_W-1:0]     r_dispatch_pc;
    logic [INST_W-1:0]   w_words [c_wpl];
    logic                w_valid;
    logic                w_accept;
    logic                w_last_word;

    genvar gi;
    generate
        for (gi = 0; gi < c_wpl; gi++) begin : g_word_split
            assign w_words[gi] = buf_data_read[gi*INST_W +: INST_W];
        end
    endgenerate

    // A redirect cycle never offers an instruction: the head line is stale.
    assign w_valid     = !buf_empty && !redirect_valid;
    assign w_accept    = w_valid && dec_ready;
    assign w_last_word = (r_rd_word == c_last_word);

    // The word index is taken from the target PC so the first line after a
    // redirect starts at the target word, skipping the earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_word     <= RESET_PC[c_ioff_w +: c_widx_w];
            r_dispatch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_rd_word     <= redirect_pc[c_ioff_w +: c_widx_w];
            r_dispatch_pc <= redirect_pc;
        end else if (w_accept) begin
            r_rd_word     <= w_last_word ? '0 : r_rd_word + c_widx_w'(1);
            r_dispatch_pc <= r_dispatch_pc + PC_W'(c_inst_bytes);
        end
    end

    assign inst_valid = !rst && w_valid;
    assign inst       = rst ? '0 : w_words[r_rd_word];
    assign inst_pc    = rst ? '0 : r_dispatch_pc;
    assign buf_pull   = !rst && w_accept && w_last_word;

endmodule : ifq_dispatch_sel
`default_nettype wire

// File: rtl/ifq_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifq_fetch_ctrl
// Purpose  : IFQ fetch sequencer. Issues one line-aligned I-cache read at a
//            time, pushes returned lines into the IFQ line buffer, flushes
//            and re-steers on branch redirect, and dispatches instructions
//            through ifq_dispatch_sel.
// Ports    : clk, rst                                 - clock, sync reset
//            redirect_valid, redirect_pc              - branch re-steer
//            icache_rd_en, icache_addr, icache_abort  - I-cache request side
//            icache_dout_valid                        - line at buffer port
//            buf_push, buf_pull, buf_flush            - buffer strobes
//            buf_full, buf_empty, buf_data_read       - buffer status / head
//            inst_valid, inst, inst_pc, dec_ready     - decode handshake
//            perf_stall_full, perf_redirects          - only with macro
// Macro    : IFQ_PERF_CNT_EN - adds saturating full-stall and redirect counters
// Revision : 1.0 - initial release
// ============================================================================
module ifq_fetch_ctrl
    import ifq_pkg::*;
#(
    parameter int              LINE_W   = IFQ_LINE_W,
    parameter int              INST_W   = IFQ_INST_W,
    parameter int              PC_W     = IFQ_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              icache_rd_en,
    output logic [PC_W-1:0]   icache_addr,
    output logic              icache_abort,
    input  logic              icache_dout_valid,
    output logic              buf_push,
    output logic              buf_pull,
    output logic              buf_flush,
    input  logic              buf_full,
    input  logic              buf_empty,
    input  logic [LINE_W-1:0] buf_data_read,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              dec_ready
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_full,
    output logic [31:0]       perf_redirects
`endif
);

    localparam int              c_line_bytes = LINE_W / 8;
    localparam logic [PC_W-1:0] c_line_mask  = ~PC_W'(c_line_bytes - 1);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic            w_req;
    logic            w_fill;

    // Requests are only made with room in the buffer, so a fill can never
    // overflow it even though the full flag is not re-checked at push time.
    assign w_req  = (r_state == S_REQ) && !buf_full && !redirect_valid;
    assign w_fill = (r_state == S_WAIT) && icache_dout_valid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC & c_line_mask;
        end else if (redirect_valid) begin
            // Any line arriving this cycle belongs to the old path and is dropped.
            r_state    <= S_REQ;
            r_fetch_pc <= redirect_pc & c_line_mask;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!buf_full) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_dout_valid) begin
                        r_state    <= S_REQ;
                        r_fetch_pc <= r_fetch_pc + PC_W'(c_line_bytes);
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign icache_rd_en = !rst && w_req;
    assign icache_addr  = rst ? '0 : r_fetch_pc;
    assign icache_abort = !rst && redirect_valid && (r_state == S_WAIT);
    assign buf_push     = !rst && w_fill;
    assign buf_flush    = !rst && redirect_valid;

    ifq_dispatch_sel #(
        .LINE_W   (LINE_W),
        .INST_W   (INST_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_dispatch (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .buf_empty      (buf_empty),
        .buf_data_read  (buf_data_read),
        .dec_ready      (dec_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .buf_pull       (buf_pull)
    );

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_redir <= '0;
        end else begin
            if ((r_state == S_REQ) && buf_full && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_valid && (r_perf_redir != '1)) begin
                r_perf_redir <= r_perf_redir + 32'd1;
            end
        end
    end

    assign perf_stall_full = rst ? '0 : r_perf_stall;
    assign perf_redirects  = rst ? '0 : r_perf_redir;
`endif

endmodule : ifq_fetch_ctrl
`default_nettype wire

// File: tb/tb_ifq_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifq_fetch_ctrl
// Purpose  : Self-checking bench for ifq_fetch_ctrl (RESET_PC = 0x100).
//            Per-cycle vector table with the buffer and I-cache driven
//            directly, followed by sequences that use a small 4-entry buffer
//            and one-cycle I-cache model for streaming and back-pressure.
// Macro    : IFQ_PERF_CNT_EN - also exercises the performance counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifq_fetch_ctrl;

    localparam logic [31:0] W0 = 32'hC0DE_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         icache_rd_en;
    logic [31:0]  icache_addr;
    logic         icache_abort;
    logic         icache_dout_valid;
    logic         buf_push, buf_pull, buf_flush;
    logic         buf_full, buf_empty;
    logic [127:0] buf_data_read;
    logic         inst_valid;
    logic [31:0]  inst, inst_pc;
    logic         dec_ready;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0]  perf_stall_full, perf_redirects;
`endif

    always #5 clk = ~clk;

    ifq_fetch_ctrl #(
        .LINE_W   (128),
        .INST_W   (32),
        .PC_W     (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .icache_rd_en      (icache_rd_en),
        .icache_addr       (icache_addr),
        .icache_abort      (icache_abort),
        .icache_dout_valid (icache_dout_valid),
        .buf_push          (buf_push),
        .buf_pull          (buf_pull),
        .buf_flush         (buf_flush),
        .buf_full          (buf_full),
        .buf_empty         (buf_empty),
        .buf_data_read     (buf_data_read),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .dec_ready         (dec_ready)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_stall_full   (perf_stall_full),
        .perf_redirects    (perf_redirects)
`endif
    );

    // ---------------- stimulus source select ----------------
    logic         model_mode;
    logic         t_full, t_empty, t_dv;
    logic [127:0] t_data;

    // Buffer / I-cache model: line word i holds its own PC (addr + 4*i).
    logic [2:0]   m_cnt;
    logic [1:0]   m_head, m_tail;
    logic [127:0] m_mem [4];
    logic         m_pend;
    logic [31:0]  m_pend_addr;
    int           m_ovf;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    assign buf_full          = model_mode ? (m_cnt == 3'd4) : t_full;
    assign buf_empty         = model_mode ? (m_cnt == 3'd0) : t_empty;
    assign buf_data_read     = model_mode ? m_mem[m_head]   : t_data;
    assign icache_dout_valid = model_mode ? m_pend          : t_dv;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= '0;
            m_head <= '0;
            m_tail <= '0;
            m_pend <= 1'b0;
            m_ovf  <= 0;
        end else begin
            m_pend <= icache_rd_en;
            if (icache_rd_en) m_pend_addr <= icache_addr;
            if (buf_flush) begin
                m_cnt  <= '0;
                m_head <= '0;
                m_tail <= '0;
            end else begin
                if (buf_push) begin
                    m_mem[m_tail] <= line_of(m_pend_addr);
                    m_tail        <= m_tail + 2'd1;
                end
                if (buf_pull) m_head <= m_head + 2'd1;
                m_cnt <= m_cnt + {2'b0, buf_push} - {2'b0, buf_pull};
                if (model_mode && ((buf_push && !buf_pull && m_cnt == 3'd4) ||
                                   (buf_pull && m_cnt == 3'd0)))
                    m_ovf <= m_ovf + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rst, rv;
        logic [31:0] rpc;
        logic        dv, full, empty, rdy;
        logic        rd_en;
        logic [31:0] addr;
        logic        abort, push, pull, flush, ivld;
        logic [31:0] inst, ipc;
    } vec_t;

    function automatic vec_t mkv(
        input logic r, input logic rv, input logic [31:0] rpc, input logic dv,
        input logic full, input logic empty, input logic rdy,
        input logic rd_en, input logic [31:0] addr, input logic abort,
        input logic push, input logic pull, input logic flush, input logic ivld,
        input logic [31:0] in, input logic [31:0] ipc);
        vec_t v;
        v.rst = r;  v.rv = rv; v.rpc = rpc; v.dv = dv; v.full = full;
        v.empty = empty; v.rdy = rdy; v.rd_en = rd_en; v.addr = addr;
        v.abort = abort; v.push = push; v.pull = pull; v.flush = flush;
        v.ivld = ivld; v.inst = in; v.ipc = ipc;
        return v;
    endfunction

    localparam int NV = 24;
    vec_t tbl [NV];

    initial begin
        int exp_pc, exp_addr, acc, n_req, n_push, n_rd, pull_at, rd_at;
        logic [101:0] act_b, exp_b;

        //            rst rv rpc           dv fu em rd | rd addr        ab pu pl fl iv inst   ipc
        tbl[0]  = mkv(1, 1, 32'h208,      1, 0, 0, 1,  0, 32'h0,       0, 0, 0, 0, 0, 32'h0, 32'h0);
        tbl[1]  = mkv(0, 0, 32'h0,        0, 0, 1, 0,  1, 32'h100,     0, 0, 0, 0, 0, W0,    32'h100);
        tbl[2]  = mkv(0, 0, 32'h0,        0, 0, 1, 0,  0, 32'h100,     0, 0, 0, 0, 0, W0,    32'h100);
        tbl[3]  = mkv(0, 0, 32'h0,        1, 0, 1, 0,  0, 32'h100,     0, 1, 0, 0, 0, W0,    32'h100);
        tbl[4]  = mkv(0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h110,     0, 0, 0, 0, 1, W0,    32'h100);
        tbl[5]  = mkv(0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h110,     0, 0, 0, 0, 1, W0+1,  32'h104);
        tbl[6]  = mkv(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h110,     0, 0, 0, 0, 1, W0+2,  32'h108);
        tbl[7]  = mkv(0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h110,     0, 0, 0, 0, 1, W0+2,  32'h108);
        tbl[8]  = mkv(0, 0, 32'h0,        1, 0, 0, 1,  0, 32'h110,     0, 1, 1, 0, 1, W0+3,  32'h10C);
        tbl[9]  = mkv(0, 0, 32'h0,        0, 1, 0, 0,  0, 32'h120,     0, 0, 0, 0, 1, W0,    32'h110);
        tbl[10] = mkv(0, 1, 32'h208,      0, 1, 0, 1,  0, 32'h120,     0, 0, 0, 1, 0, W0,    32'h110);
        tbl[11] = mkv(0, 0, 32'h0,        0, 0, 1, 0,  1, 32'h200,     0, 0, 0, 0, 0, W0+2,  32'h208);
        tbl[12] = mkv(0, 1, 32'h30C,      1, 0, 0, 1,  0, 32'h200,     1, 0, 0, 1, 0, W0+2,  32'h208);
        tbl[13] = mkv(0, 0, 32'h0,        0, 0, 1, 0,  1, 32'h300,     0, 0, 0, 0, 0, W0+3,  32'h30C);
        tbl[14] = mkv(0, 0, 32'h0,        1, 0, 1, 0,  0, 32'h300,     0, 1, 0, 0, 0, W0+3,  32'h30C);
        tbl[15] = mkv(0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h310,     0, 0, 1, 0, 1, W0+3,  32'h30C);
        tbl[16] = mkv(1, 0, 32'h0,        0, 0, 0, 1,  0, 32'h0,       0, 0, 0, 0, 0, 32'h0, 32'h0);
        tbl[17] = mkv(0, 1, 32'hFFFFFFF4, 0, 0, 1, 0,  0, 32'h100,     0, 0, 0, 1, 0, W0,    32'h100);
        tbl[18] = mkv(0, 0, 32'h0,        0, 0, 1, 0,  1, 32'hFFFFFFF0,0, 0, 0, 0, 0, W0+1,  32'hFFFFFFF4);
        tbl[19] = mkv(0, 0, 32'h0,        1, 0, 1, 0,  0, 32'hFFFFFFF0,0, 1, 0, 0, 0, W0+1,  32'hFFFFFFF4);
        tbl[20] = mkv(0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h0,       0, 0, 0, 0, 1, W0+1,  32'hFFFFFFF4);
        tbl[21] = mkv(0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h0,       0, 0, 0, 0, 1, W0+2,  32'hFFFFFFF8);
        tbl[22] = mkv(0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h0,       0, 0, 1, 0, 1, W0+3,  32'hFFFFFFFC);
        tbl[23] = mkv(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h0,       0, 0, 0, 0, 1, W0,    32'h0);

        model_mode     = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        t_full         = 1'b0;
        t_empty        = 1'b1;
        t_dv           = 1'b0;
        t_data         = {W0 + 32'd3, W0 + 32'd2, W0 + 32'd1, W0};

        // ---------- table-driven per-cycle vectors ----------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            t_dv           = tbl[i].dv;
            t_full         = tbl[i].full;
            t_empty        = tbl[i].empty;
            dec_ready      = tbl[i].rdy;
            #1;
            act_b = {icache_rd_en, icache_addr, icache_abort, buf_push, buf_pull,
                     buf_flush, inst_valid, inst, inst_pc};
            exp_b = {tbl[i].rd_en, tbl[i].addr, tbl[i].abort, tbl[i].push, tbl[i].pull,
                     tbl[i].flush, tbl[i].ivld, tbl[i].inst, tbl[i].ipc};
            chk($sformatf("vec%0d", i), {26'b0, act_b}, {26'b0, exp_b});
        end

        // ---------- streaming from reset with the buffer model ----------
        @(negedge clk);
        model_mode = 1'b1; rst = 1'b1; redirect_valid = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_pc = 32'h100; exp_addr = 32'h100; acc = 0; n_req = 0;
        for (int cyc = 0; cyc < 200 && acc < 16; cyc++) begin
            if (icache_rd_en && n_req < 5) begin
                chk($sformatf("stream_req%0d", n_req), {96'b0, icache_addr}, {96'b0, exp_addr});
                exp_addr += 32'h10;
                n_req++;
            end
            if (inst_valid && dec_ready) begin
                chk($sformatf("stream_inst%0d", acc), {63'b0, inst_pc, inst, buf_pull},
                    {63'b0, exp_pc[31:0], exp_pc[31:0], (acc % 4) == 3});
                exp_pc += 4;
                acc++;
            end
            @(negedge clk);
            #1;
        end
        chk("stream_count", 128'(acc), 128'd16);
        chk("stream_ovf", 128'(m_ovf), 128'd0);

        // ---------- back-pressure: decode stalled, buffer fills ----------
        @(negedge clk);
        rst = 1'b1; dec_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_push = 0; n_rd = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (buf_push) n_push++;
            if (icache_rd_en) n_rd++;
            @(negedge clk);
            #1;
        end
        chk("full_pushes", 128'(n_push), 128'd4);
        chk("full_requests", 128'(n_rd), 128'd4);
        chk("full_flag", {127'b0, buf_full}, 128'd1);
        dec_ready = 1'b1;
        #1;
        pull_at = -1; rd_at = -1;
        for (int cyc = 0; cyc < 12 && rd_at < 0; cyc++) begin
            if (buf_pull && pull_at < 0) pull_at = cyc;
            if (icache_rd_en) begin
                rd_at = cyc;
                chk("resume_addr", {96'b0, icache_addr}, {96'b0, 32'h140});
            end
            @(negedge clk);
            #1;
        end
        chk("resume_pull_cycle", 128'(pull_at), 128'd3);
        chk("resume_req_cycle", 128'(rd_at), 128'd4);
        chk("full_ovf", 128'(m_ovf), 128'd0);

`ifdef IFQ_PERF_CNT_EN
        // ---------- performance counters ----------
        @(negedge clk);
        model_mode = 1'b0; rst = 1'b1; dec_ready = 1'b0;
        t_full = 1'b1; t_empty = 1'b1; t_dv = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        t_full = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("perf_stall", {96'b0, perf_stall_full}, 128'd10);
        chk("perf_redir", {96'b0, perf_redirects}, 128'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("perf_clear", {64'b0, perf_stall_full, perf_redirects}, 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ifq_fetch_ctrl
`default_nettype wire

// File: doc/ifq_fetch_ctrl.md
Name: ifq_fetch_ctrl

Overview:
Fetch sequencer for the instruction fetch queue (IFQ). Issues line-aligned I-cache reads one at a time and pushes returned lines into the IFQ line buffer. Slices buffered lines into single instructions, with PCs, for decode. On a branch redirect it flushes the buffer and re-steers fetch. It owns every push/pull/flush strobe of the buffer.

Parameters:
LINE_W, 128, bits per fetch line / buffer entry
INST_W, 32, bits per instruction; LINE_W/INST_W = WPL, a power of two (default 4)
PC_W, 32, PC width
RESET_PC, 0, fetch/dispatch PC after reset (INST_W/8-aligned)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_valid  in  1  branch redirect request, single cycle
redirect_pc  in  PC_W  redirect target, instruction-aligned
icache_rd_en  out  1  read request strobe, single cycle
icache_addr  out  PC_W  line-aligned read address
icache_abort  out  1  cancel the outstanding read
icache_dout_valid  in  1  requested line is present at the buffer write port
buf_push  out  1  buffer push
buf_pull  out  1  buffer pull
buf_flush  out  1  buffer synchronous flush
buf_full  in  1  buffer full flag (registered)
buf_empty  in  1  buffer empty flag (registered)
buf_data_read  in  LINE_W  buffer head line
inst_valid  out  1  instruction offered to decode
inst  out  INST_W  instruction
inst_pc  out  PC_W  instruction PC
dec_ready  in  1  decode accepts

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state S_REQ; fetch_pc = RESET_PC with the line offset cleared; rd_word = RESET_PC word index; dispatch_pc = RESET_PC.
- While rst=1, every output is 0.
- FSM states: S_REQ, S_WAIT.
- S_REQ, with !buf_full and !redirect_valid:
  - Assert icache_rd_en with icache_addr = fetch_pc.
  - Next state S_WAIT.
  - If buf_full, hold S_REQ with no request.
- S_WAIT, on icache_dout_valid and !redirect_valid:
  - buf_push=1 in the same cycle.
  - fetch_pc += LINE_W/8, wrapping modulo 2^PC_W.
  - Next state S_REQ.
- At most one read outstanding. A request is issued only when !buf_full, so a push can never hit a full buffer.
- Redirect, in any state:
  - buf_flush=1 in the same cycle.
  - icache_abort=1 if the state is S_WAIT.
  - A coincident icache_dout_valid is discarded, with no push.
  - fetch_pc = redirect_pc line-aligned; rd_word = redirect_pc word index; dispatch_pc = redirect_pc.
  - Next state S_REQ.
- Dispatch outputs:
  - inst_valid = !buf_empty && !redirect_valid.
  - inst = word rd_word of buf_data_read, where word 0 is the LSBs.
  - inst_pc = dispatch_pc.
- Handshake (inst_valid && dec_ready):
  - dispatch_pc += INST_W/8.
  - If rd_word == WPL-1: buf_pull=1 and rd_word = 0. Otherwise rd_word += 1.
- After a redirect, the first line is consumed starting at the redirect word offset. Earlier words of that line are skipped.
- Latency: icache_dout_valid in cycle N → inst_valid in cycle N+1 (empty flag is registered).
- Push and pull may occur in the same cycle; the buffer resolves both.
- Redirect takes priority over the handshake: no pull and no PC advance that cycle.

Optional Feature:
IFQ_PERF_CNT_EN:
- Defined:
  - Adds output ports perf_stall_full (32b) and perf_redirects (32b).
  - perf_stall_full counts cycles spent in S_REQ with buf_full=1.
  - perf_redirects counts redirect_valid cycles.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent, and there is no logic change otherwise.

Decomposition:
- Package ifq_pkg holds:
  - fetch_state_t enum {S_REQ, S_WAIT};
  - localparams LINE_BYTES, INST_BYTES, WPL, WIDX_W = $clog2(WPL).
- Sub-module ifq_dispatch_sel holds rd_word, dispatch_pc, the word mux and buf_pull generation.
- The top IFQ wires ifq_fetch_ctrl to the line buffer.

Test Plan:
- Reset with RESET_PC=0x100, icache_dout_valid one cycle after each request → reads at 0x100, 0x110, 0x120…; inst_pc 0x100, 0x104, …; buf_pull on every 4th accept.
- dec_ready=0 with 4-entry buffer → exactly 4 pushes, then icache_rd_en stays 0 while buf_full=1; dec_ready=1 resumes fetch after the first pull.
- redirect_pc=0x208 while in S_WAIT with coincident icache_dout_valid → buf_flush=1, icache_abort=1, no push; next request at 0x200; first inst_pc=0x208 (word 2), buf_pull after word 3.
- Redirect in the same cycle as a dispatch handshake → no buf_pull, inst_valid=0 that cycle; next inst_pc is the redirect target.
- Fetch at 0xFFFFFFF0 → next request wraps to 0x00000000; dispatch_pc wraps likewise.
- IFQ_PERF_CNT_EN defined, 3 redirects and 10 full-stall cycles → perf_redirects=3, perf_stall_full=10; rst clears both.
